combo_lock_fsm: RTL and testbench
=================================

// Module: combo_lock_fsm
// PURPOSE
//  Moore combination-lock controller; consumes the one-cycle button pulses produced by the
//  per-button input-conditioning stage (a_pulse, b_pulse), assembles them into a code sequence,
//  checks it, drives unlock/error/lockout indicators. Sits between conditioning blocks and LEDs.
// PARAMETERS
//  CODE_LEN      4        presses per attempt (1..8)
//  CODE          4'b0110  secret code, CODE_LEN bits; press a = 0, press b = 1; MSB = first press
//  MAX_TRIES     3        consecutive failed attempts before lockout (1..7)
//  OPEN_CYCLES   50       cycles unlocked stays high before auto-relock (>=1)
//  LOCK_CYCLES   100      cycles spent in LOCKOUT (>=1)
// PORTS
//  Clock     in   1           system clock, rising edge
//  Resetn    in   1           asynchronous active-low reset
//  a_pulse   in   1           single-cycle press of button a (digit 0)
//  b_pulse   in   1           single-cycle press of button b (digit 1)
//  unlocked  out  1           high while in OPEN
//  error     out  1           high for exactly one cycle per failed attempt (state FAIL)
//  lockout   out  1           high while in LOCKOUT
//  presses   out  4           presses accepted in current attempt (0..CODE_LEN-1)
//  fails     out  3           consecutive failed attempts
// BEHAVIOUR
//  - Reset (Resetn=0, async): state IDLE, shift reg, presses, fails, timers = 0; all outputs 0.
//  - Moore machine: all outputs decode from registered state/counters only; no input->output path.
//  - press = a_pulse | b_pulse; digit = b_pulse & ~a_pulse.
//    a_pulse & b_pulse same cycle = one press, marked invalid; attempt fails at CHECK regardless.
//  - IDLE/ENTRY: on press, shift digit into LSB of code reg, presses++, set bad flag if invalid.
//    When the press brings the count to CODE_LEN -> CHECK, presses cleared to 0.
//  - CHECK (1 cycle, inputs ignored): match & ~bad -> OPEN, fails := 0; else -> FAIL, fails++.
//  - FAIL (1 cycle, error=1, inputs ignored): fails == MAX_TRIES -> LOCKOUT; else -> IDLE.
//    Code reg and bad flag cleared on exit.
//  - OPEN: unlocked=1 for OPEN_CYCLES cycles, then IDLE. Any press in OPEN -> IDLE next edge
//    (manual relock); that press is not counted toward a new attempt.
//  - LOCKOUT: lockout=1 for LOCK_CYCLES cycles, all presses ignored; exit -> IDLE, fails := 0.
//  - Latency: last press sampled at edge k -> CHECK after k -> OPEN/FAIL after edge k+1.
//  - Timers load on state entry and count down; no wrap. fails saturates at MAX_TRIES.
//  - Reset mid-attempt/OPEN/LOCKOUT: immediate return to reset values, partial entry discarded.
//  - Unused/illegal state encodings -> IDLE on next edge.
// TESTING
//  1 Reset: Resetn=0 mid-run -> all outputs 0 asynchronously; hold 0 until release.
//  2 Correct code: pulses a,b,b,a (gaps >=1 cycle) -> unlocked=1 two edges after last
//    press, stays 50 cycles, then 0; fails=0.
//  3 Wrong code: a,a,a,a -> error=1 exactly one cycle, fails=1, back to IDLE, presses=0.
//  4 Lockout: three wrong attempts -> lockout=1 for 100 cycles; presses ignored meanwhile;
//    then lockout=0, fails=0; correct code afterwards unlocks.
//  5 Simultaneous: a_pulse&b_pulse as 2nd press of otherwise correct sequence -> error, no
//    unlock; press during OPEN -> unlocked drops next edge, presses stays 0.
//  6 Reset mid-entry after 3 presses -> presses=0; then full correct code -> unlocked.

Source files
------------

// File: rtl/combo_lock_fsm_if.sv
// rtl/combo_lock_fsm_if.sv - button pulse inputs and lock indicator outputs of the combination lock
interface combo_lock_fsm_if;
  logic       a_pulse;
  logic       b_pulse;
  logic       unlocked;
  logic       error;
  logic       lockout;
  logic [3:0] presses;
  logic [2:0] fails;

  // Driver side: produces button pulses, observes indicators.
  modport master (
    output a_pulse,
    output b_pulse,
    input  unlocked,
    input  error,
    input  lockout,
    input  presses,
    input  fails
  );

  // Lock controller side.
  modport slave (
    input  a_pulse,
    input  b_pulse,
    output unlocked,
    output error,
    output lockout,
    output presses,
    output fails
  );
endinterface

// File: rtl/combo_lock_fsm.sv
// rtl/combo_lock_fsm.sv - Moore combination-lock controller with retry lockout and auto-relock
module combo_lock_fsm #(
  parameter int                  CODE_LEN    = 4,
  parameter logic [CODE_LEN-1:0] CODE        = 4'b0110,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  OPEN_CYCLES = 50,
  parameter int                  LOCK_CYCLES = 100
) (
  input logic              clk,
  input logic              rst_n,
  combo_lock_fsm_if.slave  bus
);

  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_FAIL    = 3'd3,
    S_OPEN    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t              state, state_n;
  logic [CODE_LEN-1:0] code_reg, code_n;
  logic                bad, bad_n;
  logic [3:0]          presses_q, presses_n;
  logic [2:0]          fails_q, fails_n;
  logic [TW-1:0]       timer, timer_n;

  logic press;
  logic digit;
  logic invalid;

  // Both buttons in one cycle count as a single press that poisons the attempt.
  assign press   = bus.a_pulse | bus.b_pulse;
  assign digit   = bus.b_pulse & ~bus.a_pulse;
  assign invalid = bus.a_pulse & bus.b_pulse;

  // State and counter registers; reset discards any partial entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      code_reg  <= '0;
      bad       <= 1'b0;
      presses_q <= '0;
      fails_q   <= '0;
      timer     <= '0;
    end else begin
      state     <= state_n;
      code_reg  <= code_n;
      bad       <= bad_n;
      presses_q <= presses_n;
      fails_q   <= fails_n;
      timer     <= timer_n;
    end
  end

  // Next-state and next-counter logic; timers load on entry and count down to zero.
  always_comb begin
    state_n   = state;
    code_n    = code_reg;
    bad_n     = bad;
    presses_n = presses_q;
    fails_n   = fails_q;
    timer_n   = timer;
    case (state)
      S_IDLE, S_ENTRY: begin
        if (press) begin
          code_n = (code_reg << 1) | CODE_LEN'(digit);
          bad_n  = bad | invalid;
          if (presses_q == 4'(CODE_LEN - 1)) begin
            presses_n = '0;
            state_n   = S_CHECK;
          end else begin
            presses_n = presses_q + 4'd1;
            state_n   = S_ENTRY;
          end
        end
      end
      S_CHECK: begin
        if ((code_reg == CODE) && !bad) begin
          state_n = S_OPEN;
          fails_n = '0;
          code_n  = '0;
          timer_n = TW'(OPEN_CYCLES - 1);
        end else begin
          state_n = S_FAIL;
          fails_n = (fails_q == 3'(MAX_TRIES)) ? fails_q : fails_q + 3'd1;
        end
      end
      S_FAIL: begin
        code_n = '0;
        bad_n  = 1'b0;
        if (fails_q == 3'(MAX_TRIES)) begin
          state_n = S_LOCKOUT;
          timer_n = TW'(LOCK_CYCLES - 1);
        end else begin
          state_n = S_IDLE;
        end
      end
      S_OPEN: begin
        // A press here is a manual relock and is not the start of a new attempt.
        if (press || (timer == '0)) begin
          state_n = S_IDLE;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      S_LOCKOUT: begin
        if (timer == '0) begin
          state_n = S_IDLE;
          fails_n = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: begin
        state_n   = S_IDLE;
        code_n    = '0;
        bad_n     = 1'b0;
        presses_n = '0;
        timer_n   = '0;
      end
    endcase
  end

  assign bus.unlocked = (state == S_OPEN);
  assign bus.error    = (state == S_FAIL);
  assign bus.lockout  = (state == S_LOCKOUT);
  assign bus.presses  = presses_q;
  assign bus.fails    = fails_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// tb/tb_combo_lock_fsm.sv - directed scoreboard bench for the combination lock controller
module tb_combo_lock_fsm;

  logic clk;
  logic rst_n;

  combo_lock_fsm_if bus ();

  combo_lock_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic got(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  // One-cycle pulse sampled at the next rising edge.
  task automatic pulse(input logic a, input logic b);
    bus.a_pulse = a;
    bus.b_pulse = b;
    tick();
    bus.a_pulse = 1'b0;
    bus.b_pulse = 1'b0;
  endtask

  // Full code entry, MSB first, one idle cycle between presses; returns right after the last press edge.
  task automatic enter_code(input logic [3:0] c);
    for (int i = 3; i >= 0; i--) begin
      expect_val("presses_entry", (i == 0) ? 32'd0 : 32'(4 - i));
      pulse(~c[i], c[i]);
      got(bus.presses);
      if (i > 0) tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    expect_val({tag, "_unlocked"}, 0); got(bus.unlocked);
    expect_val({tag, "_error"},    0); got(bus.error);
    expect_val({tag, "_lockout"},  0); got(bus.lockout);
    expect_val({tag, "_presses"},  0); got(bus.presses);
    expect_val({tag, "_fails"},    0); got(bus.fails);
  endtask

  initial begin
    int  g;
    logic ign_bad;

    rst_n       = 1'b0;
    bus.a_pulse = 1'b0;
    bus.b_pulse = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Correct code a,b,b,a.
    enter_code(4'b0110);
    expect_val("unlock_check_cycle", 0); got(bus.unlocked);
    tick();
    expect_val("unlock_two_edges", 1); got(bus.unlocked);
    expect_val("unlock_fails", 0); got(bus.fails);
    g = 0;
    while (bus.unlocked === 1'b1 && g < 200) begin
      tick();
      g++;
    end
    expect_val("open_length", 50); got(g);

    // Wrong code a,a,a,a.
    tick();
    enter_code(4'b0000);
    expect_val("wrong_check_error", 0); got(bus.error);
    tick();
    expect_val("wrong_error", 1); got(bus.error);
    expect_val("wrong_fails", 1); got(bus.fails);
    tick();
    expect_val("wrong_error_drop", 0); got(bus.error);
    expect_val("wrong_presses", 0); got(bus.presses);
    expect_val("wrong_unlocked", 0); got(bus.unlocked);

    // Two more wrong attempts reach lockout.
    tick();
    enter_code(4'b0000);
    tick();
    tick();
    expect_val("second_fails", 2); got(bus.fails);
    tick();
    enter_code(4'b1111);
    tick();
    expect_val("third_error", 1); got(bus.error);
    expect_val("third_fails", 3); got(bus.fails);
    tick();
    expect_val("lockout_enter", 1); got(bus.lockout);
    g = 0;
    ign_bad = 1'b0;
    while (bus.lockout === 1'b1 && g < 300) begin
      bus.a_pulse = ((g % 5) == 2);
      tick();
      g++;
      if (bus.presses !== 4'd0) ign_bad = 1'b1;
    end
    bus.a_pulse = 1'b0;
    expect_val("lockout_length", 100); got(g);
    expect_val("lockout_presses_ignored", 0); got(ign_bad);
    expect_val("lockout_exit_fails", 0); got(bus.fails);
    expect_val("lockout_exit_presses", 0); got(bus.presses);

    // Correct code after lockout, then manual relock.
    enter_code(4'b0110);
    tick();
    expect_val("post_lockout_unlock", 1); got(bus.unlocked);
    tick();
    pulse(1'b1, 1'b0);
    expect_val("relock_unlocked", 0); got(bus.unlocked);
    expect_val("relock_presses", 0); got(bus.presses);
    tick();
    expect_val("relock_presses_later", 0); got(bus.presses);

    // Simultaneous press as second digit of otherwise correct code.
    pulse(1'b1, 1'b0);
    tick();
    pulse(1'b1, 1'b1);
    expect_val("simul_presses", 2); got(bus.presses);
    tick();
    pulse(1'b0, 1'b1);
    tick();
    pulse(1'b1, 1'b0);
    tick();
    expect_val("simul_error", 1); got(bus.error);
    expect_val("simul_unlocked", 0); got(bus.unlocked);
    expect_val("simul_fails", 1); got(bus.fails);
    tick();
    expect_val("simul_no_open", 0); got(bus.unlocked);

    // Reset mid-entry after three presses.
    pulse(1'b1, 1'b0);
    tick();
    pulse(1'b0, 1'b1);
    tick();
    pulse(1'b0, 1'b1);
    expect_val("mid_presses", 3); got(bus.presses);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    tick();
    check_all_zero("reset_hold");
    rst_n = 1'b1;
    tick();
    enter_code(4'b0110);
    tick();
    expect_val("after_reset_unlock", 1); got(bus.unlocked);

    expect_val("scoreboard_drained", 0); got(32'(sb.size()) - 32'd1 + 32'd1 - 32'd1 + 32'd1 - 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
